// File: rtl/int_entry_seq_if.sv
// Bus and core-handoff signals of the 6502 interrupt/BRK/reset entry sequencer.
// The master modport is the sequencer side; slave is the core/bus side.
interface int_entry_seq_if;
  logic        start;
  logic        req_rst;
  logic        req_nmi;
  logic        req_irq;
  logic [15:0] pc_in;
  logic [7:0]  p_in;
  logic [7:0]  sp_in;
  logic [7:0]  data_in;
  logic [15:0] addr;
  logic [7:0]  data_out;
  logic        rw;
  logic        busy;
  logic        done;
  logic [15:0] pc_out;
  logic        pc_we;
  logic [7:0]  sp_out;
  logic        sp_we;
  logic        set_i;
  logic        nmi_ack;
  logic [2:0]  state_dbg;

  // Handshake: start is a request sampled only while busy is low (IDLE, which
  // includes the done cycle); there is no stall, so done follows start by 6 edges.
  modport master (
    input  start, req_rst, req_nmi, req_irq, pc_in, p_in, sp_in, data_in,
    output addr, data_out, rw, busy, done, pc_out, pc_we, sp_out, sp_we,
           set_i, nmi_ack, state_dbg
  );

  modport slave (
    output start, req_rst, req_nmi, req_irq, pc_in, p_in, sp_in, data_in,
    input  addr, data_out, rw, busy, done, pc_out, pc_we, sp_out, sp_we,
           set_i, nmi_ack, state_dbg
  );
endinterface

// File: rtl/int_entry_seq.sv
// 6502 interrupt/BRK/reset entry sequencer: dummy read, three stack pushes, vector fetch.
// Optional macro NMI_HIJACK_EN lets a late NMI steal the vector of an IRQ/BRK entry.
module int_entry_seq #(
  parameter logic [7:0]  STACK_PAGE = 8'h01,
  parameter logic [15:0] VEC_NMI    = 16'hFFFA,
  parameter logic [15:0] VEC_RST    = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ    = 16'hFFFE
) (
  input  logic           clk,
  input  logic           rst_n,
  int_entry_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_DUMMY, S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P, S_VEC_LO, S_VEC_HI
  } state_t;

  state_t      state;
  logic [7:0]  sp;
  logic [15:0] push_pc;
  logic [7:0]  p_push;
  logic [15:0] vector;
  logic        is_rst;
  logic        can_hijack;
  logic [7:0]  vec_lo;

  logic        start_brk;
  logic [15:0] vec_next;
  logic [7:0]  sp_dec;

  always_comb begin
    start_brk = ~(bus.req_rst | bus.req_nmi | bus.req_irq);
    sp_dec    = sp - 8'd1;
    vec_next  = vector;
`ifdef NMI_HIJACK_EN
    if (can_hijack && bus.req_nmi) vec_next = VEC_NMI;
`endif
  end

  assign bus.state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      sp           <= 8'h00;
      push_pc      <= 16'h0000;
      p_push       <= 8'h00;
      vector       <= 16'h0000;
      is_rst       <= 1'b0;
      can_hijack   <= 1'b0;
      vec_lo       <= 8'h00;
      bus.addr     <= 16'h0000;
      bus.data_out <= 8'h00;
      bus.rw       <= 1'b1;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.pc_out   <= 16'h0000;
      bus.pc_we    <= 1'b0;
      bus.sp_out   <= 8'h00;
      bus.sp_we    <= 1'b0;
      bus.set_i    <= 1'b0;
      bus.nmi_ack  <= 1'b0;
    end else begin
      bus.done    <= 1'b0;
      bus.pc_we   <= 1'b0;
      bus.sp_we   <= 1'b0;
      bus.set_i   <= 1'b0;
      bus.nmi_ack <= 1'b0;
      // Outputs are registered one state ahead: each edge loads the bus values
      // that belong to the state being entered.
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            is_rst     <= bus.req_rst;
            can_hijack <= ~bus.req_rst & ~bus.req_nmi;
            vector     <= bus.req_rst ? VEC_RST : (bus.req_nmi ? VEC_NMI : VEC_IRQ);
            push_pc    <= bus.pc_in + {15'd0, start_brk};
            // Bit 5 always set in the pushed copy; B (bit 4) marks software entry.
            p_push     <= start_brk ? (bus.p_in | 8'h30) : ((bus.p_in | 8'h20) & 8'hEF);
            sp         <= bus.sp_in;
            bus.addr     <= bus.pc_in;
            bus.data_out <= 8'h00;
            bus.rw       <= 1'b1;
            bus.busy     <= 1'b1;
            state        <= S_DUMMY;
          end
        end
        S_DUMMY: begin
          bus.addr     <= {STACK_PAGE, sp};
          bus.data_out <= is_rst ? 8'h00 : push_pc[15:8];
          bus.rw       <= is_rst;
          state        <= S_PUSH_PCH;
        end
        S_PUSH_PCH: begin
          sp           <= sp_dec;
          vector       <= vec_next;
          bus.addr     <= {STACK_PAGE, sp_dec};
          bus.data_out <= is_rst ? 8'h00 : push_pc[7:0];
          state        <= S_PUSH_PCL;
        end
        S_PUSH_PCL: begin
          sp           <= sp_dec;
          vector       <= vec_next;
          bus.addr     <= {STACK_PAGE, sp_dec};
          bus.data_out <= is_rst ? 8'h00 : p_push;
          state        <= S_PUSH_P;
        end
        S_PUSH_P: begin
          sp           <= sp_dec;
          vector       <= vec_next;
          bus.addr     <= vec_next;
          bus.data_out <= 8'h00;
          bus.rw       <= 1'b1;
          state        <= S_VEC_LO;
        end
        S_VEC_LO: begin
          vec_lo   <= bus.data_in;
          bus.addr <= vector + 16'd1;
          state    <= S_VEC_HI;
        end
        S_VEC_HI: begin
          bus.pc_out  <= {bus.data_in, vec_lo};
          bus.sp_out  <= sp;
          bus.pc_we   <= 1'b1;
          bus.sp_we   <= 1'b1;
          bus.set_i   <= 1'b1;
          bus.done    <= 1'b1;
          bus.nmi_ack <= (vector == VEC_NMI);
          bus.addr    <= 16'h0000;
          bus.busy    <= 1'b0;
          state       <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
          bus.rw   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_entry_seq.sv
// Randomized self-checking bench for int_entry_seq against a trace-level model of the entry sequence.
module tb_int_entry_seq;

  logic clk;
  logic rst_n;
  int_entry_seq_if bus_if();

  int_entry_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected bus trace entries: {addr, rw, data_out, busy}
  logic [25:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void model(input bit r_rst, input bit r_nmi, input bit r_irq,
                                input logic [15:0] pc, input logic [7:0] p,
                                input logic [7:0] sp, input int nmi_cycle,
                                output logic [15:0] vec, output bit ack);
    bit          brk;
    logic [15:0] ppc;
    logic [7:0]  pushes [3];
    logic [7:0]  a;
    brk = !(r_rst || r_nmi || r_irq);
    ppc = brk ? pc + 16'd1 : pc;
    pushes[0] = ppc[15:8];
    pushes[1] = ppc[7:0];
    pushes[2] = brk ? (p | 8'h30) : ((p | 8'h20) & 8'hEF);
    vec = r_rst ? 16'hFFFC : (r_nmi ? 16'hFFFA : 16'hFFFE);
`ifdef NMI_HIJACK_EN
    if (!r_rst && !r_nmi && nmi_cycle >= 1 && nmi_cycle <= 3) vec = 16'hFFFA;
`endif
    ack = (vec == 16'hFFFA);
    exp_q.push_back({pc, 1'b1, 8'h00, 1'b1});
    for (int i = 0; i < 3; i++) begin
      a = sp - 8'(i);
      exp_q.push_back({8'h01, a, r_rst ? 1'b1 : 1'b0, r_rst ? 8'h00 : pushes[i], 1'b1});
    end
    exp_q.push_back({vec, 1'b1, 8'h00, 1'b1});
    exp_q.push_back({vec + 16'd1, 1'b1, 8'h00, 1'b1});
  endfunction

  // ---------------- driver tasks ----------------
  // Called with DUT idle (or in its done cycle); returns at the negedge of the done cycle.
  task automatic run_seq(input string name, input bit r_rst, input bit r_nmi, input bit r_irq,
                         input logic [15:0] pc, input logic [7:0] p, input logic [7:0] sp,
                         input logic [15:0] vdata, input int nmi_cycle, input int stray_k);
    logic [15:0] vec;
    bit          ack;
    logic [25:0] got, exp;
    logic [33:0] got_r, exp_r;
    logic [7:0]  sp_end;
    model(r_rst, r_nmi, r_irq, pc, p, sp, nmi_cycle, vec, ack);
    sp_end = sp - 8'd3;
    exp_r = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, ack, vdata, sp_end};
    bus_if.start   = 1'b1;
    bus_if.req_rst = r_rst;
    bus_if.req_nmi = r_nmi;
    bus_if.req_irq = r_irq;
    bus_if.pc_in   = pc;
    bus_if.p_in    = p;
    bus_if.sp_in   = sp;
    @(posedge clk); #1;
    bus_if.pc_in = 16'($urandom);
    bus_if.p_in  = 8'($urandom);
    bus_if.sp_in = 8'($urandom);
    for (int k = 0; k < 6; k++) begin
      bus_if.start   = (k == stray_k);
      bus_if.req_nmi = (k == nmi_cycle);
      bus_if.req_irq = 1'($urandom_range(0, 1));
      bus_if.req_rst = 1'($urandom_range(0, 1));
      bus_if.data_in = (k == 4) ? vdata[7:0] : ((k == 5) ? vdata[15:8] : 8'($urandom));
      @(negedge clk);
      got = {bus_if.addr, bus_if.rw, bus_if.data_out, bus_if.busy};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s bus cycle %0d: got addr=%h rw=%b dout=%h busy=%b, expected addr=%h rw=%b dout=%h busy=%b",
                 name, k, got[25:10], got[9], got[8:1], got[0], exp[25:10], exp[9], exp[8:1], exp[0]);
      end
      @(posedge clk); #1;
    end
    bus_if.start   = 1'b0;
    bus_if.req_nmi = 1'b0;
    bus_if.req_irq = 1'b0;
    bus_if.req_rst = 1'b0;
    @(negedge clk);
    got_r = {bus_if.busy, bus_if.done, bus_if.pc_we, bus_if.sp_we, bus_if.set_i,
             bus_if.nmi_ack, bus_if.pc_out, bus_if.sp_out};
    n_checks++;
    if (got_r !== exp_r) begin
      n_fail++;
      $display("FAIL %s result: got busy/done/pcwe/spwe/seti/ack=%b pc_out=%h sp_out=%h, expected %b pc_out=%h sp_out=%h",
               name, got_r[33:28], got_r[23:8], got_r[7:0], exp_r[33:28], exp_r[23:8], exp_r[7:0]);
    end
  endtask

  // Idle n cycles; the first idle cycle must show the done-cycle pulses cleared.
  task automatic idle(input int n);
    bus_if.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        @(negedge clk);
        n_checks++;
        if ({bus_if.busy, bus_if.done, bus_if.pc_we, bus_if.sp_we, bus_if.set_i, bus_if.nmi_ack} !== 6'b0) begin
          n_fail++;
          $display("FAIL pulse clear: got busy/done/pcwe/spwe/seti/ack=%b, expected 000000",
                   {bus_if.busy, bus_if.done, bus_if.pc_we, bus_if.sp_we, bus_if.set_i, bus_if.nmi_ack});
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [60:0] got;
    got = {bus_if.addr, bus_if.data_out, bus_if.rw, bus_if.busy, bus_if.done, bus_if.pc_we,
           bus_if.sp_we, bus_if.set_i, bus_if.nmi_ack, bus_if.pc_out, bus_if.sp_out, bus_if.state_dbg};
    n_checks++;
    if (got !== {16'h0, 8'h0, 1'b1, 6'b0, 16'h0, 8'h0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset state: got %h, expected %h", got, {16'h0, 8'h0, 1'b1, 6'b0, 16'h0, 8'h0, 3'd0});
    end
  endtask

  task automatic test_irq();
    run_seq("irq", 0, 0, 1, 16'h1234, 8'h00, 8'hFD, 16'h8000, -1, -1);
    idle(2);
  endtask

  task automatic test_brk();
    run_seq("brk", 0, 0, 0, 16'h0200, 8'hC3, 8'hFF, 16'h1357, -1, -1);
    idle(2);
    run_seq("brk wrap", 0, 0, 0, 16'hFFFF, 8'h00, 8'h01, 16'hABCD, -1, 2);
    idle(1);
  endtask

  task automatic test_rst();
    run_seq("rst", 1, 0, 0, 16'h4000, 8'h5A, 8'h00, 16'hC000, -1, -1);
    idle(2);
  endtask

  task automatic test_priority();
    run_seq("prio nmi", 0, 1, 1, 16'h2222, 8'h81, 8'hF0, 16'h9000, -1, -1);
    idle(1);
    run_seq("prio rst", 1, 1, 1, 16'h3333, 8'h81, 8'hF0, 16'hA000, -1, -1);
    idle(1);
  endtask

  task automatic test_async_reset();
    int bad;
    bus_if.start = 1'b1; bus_if.req_irq = 1'b1; bus_if.req_nmi = 1'b0; bus_if.req_rst = 1'b0;
    bus_if.pc_in = 16'h5555; bus_if.p_in = 8'h00; bus_if.sp_in = 8'hF8;
    @(posedge clk); #1;
    bus_if.start = 1'b0; bus_if.req_irq = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus_if.busy, bus_if.rw, bus_if.addr, bus_if.pc_we, bus_if.sp_we} !== {1'b0, 1'b1, 16'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL async reset: got busy=%b rw=%b addr=%h pcwe=%b spwe=%b, expected 0 1 0000 0 0",
               bus_if.busy, bus_if.rw, bus_if.addr, bus_if.pc_we, bus_if.sp_we);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_if.pc_we || bus_if.sp_we || bus_if.set_i || bus_if.done || bus_if.busy || bus_if.sp_out !== 8'h00) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL async reset quiet: got %0d cycles with activity, expected 0", bad);
    end
    run_seq("after async reset", 0, 0, 1, 16'h6000, 8'h04, 8'h10, 16'h7000, -1, -1);
    idle(1);
  endtask

  task automatic test_hijack();
    run_seq("hijack irq", 0, 0, 1, 16'h1234, 8'h00, 8'hFD, 16'h8000, 2, -1);
    idle(1);
    run_seq("hijack brk", 0, 0, 0, 16'h0300, 8'h00, 8'h80, 16'h8100, 3, -1);
    idle(1);
  endtask

  task automatic test_back_to_back();
    run_seq("b2b first", 0, 0, 1, 16'h0100, 8'hFF, 8'h20, 16'h1111, -1, -1);
    run_seq("b2b second", 0, 1, 0, 16'h0200, 8'h00, 8'h1D, 16'h2222, -1, -1);
    run_seq("b2b third", 1, 0, 0, 16'h0300, 8'h00, 8'h1A, 16'h3333, -1, 0);
    idle(1);
  endtask

  task automatic test_random();
    bit r_rst, r_nmi, r_irq;
    int nc, sk;
    for (int it = 0; it < 20; it++) begin
      r_rst = 1'($urandom_range(0, 3) == 0);
      r_nmi = 1'($urandom_range(0, 2) == 0);
      r_irq = 1'($urandom_range(0, 1));
      nc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : -1;
      sk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1;
      run_seq("random", r_rst, r_nmi, r_irq, 16'($urandom), 8'($urandom), 8'($urandom),
              16'($urandom), nc, sk);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(1);
  endtask

  // ---------------- main ----------------
  initial begin
    rst_n = 1'b0;
    bus_if.start = 1'b0; bus_if.req_rst = 1'b0; bus_if.req_nmi = 1'b0; bus_if.req_irq = 1'b0;
    bus_if.pc_in = 16'h0; bus_if.p_in = 8'h0; bus_if.sp_in = 8'h0; bus_if.data_in = 8'h0;
    #12;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    test_irq();
    test_brk();
    test_rst();
    test_priority();
    test_async_reset();
    test_hijack();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/int_entry_seq.md
Name: int_entry_seq

Overview:
- 6502 interrupt/BRK/reset entry sequencer; consumes the prioritised rst/nmi/irq requests plus the decoded BRK opcode.
- Drives the bus through the 6-cycle entry sequence:
  - dummy read
  - push PCH, push PCL, push P
  - fetch vector low, fetch vector high
- Hands the new PC, new SP and I-flag set back to the core.
- Sits inside the 6502 core between the interrupt request logic and the bus mux.

Parameters:
- STACK_PAGE, 8'h01, high address byte for stack pushes.
- VEC_NMI, 16'hFFFA, NMI vector low-byte address.
- VEC_RST, 16'hFFFC, reset vector low-byte address.
- VEC_IRQ, 16'hFFFE, IRQ/BRK vector low-byte address.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin sequence; sampled only in IDLE.
- req_rst  in  1  reset request (highest priority).
- req_nmi  in  1  NMI request.
- req_irq  in  1  IRQ request.
- pc_in  in  16  current PC (address of byte after opcode).
- p_in  in  8  current status register.
- sp_in  in  8  current stack pointer.
- data_in  in  8  bus read data.
- addr  out  16  bus address.
- data_out  out  8  bus write data.
- rw  out  1  1=read, 0=write.
- busy  out  1  high in any non-IDLE state.
- done  out  1  one-cycle pulse after vector fetch.
- pc_out  out  16  loaded vector.
- pc_we  out  1  one-cycle pulse, coincident with done.
- sp_out  out  8  updated stack pointer.
- sp_we  out  1  one-cycle pulse, coincident with done.
- set_i  out  1  one-cycle pulse, coincident with done.
- nmi_ack  out  1  one-cycle pulse with done when NMI vector used.

Behaviour:
- States: IDLE, DUMMY, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI.
- Each state lasts exactly one clock; no stalls.
- Reset (rst_n low, async):
  - State IDLE.
  - addr=0, data_out=0, rw=1.
  - busy, done, pc_we, sp_we, set_i, nmi_ack = 0.
  - pc_out=0, sp_out=0.
- IDLE + start at a rising edge:
  - Latch kind by priority: RST if req_rst, else NMI if req_nmi, else IRQ if req_irq, else BRK.
  - Latch push_pc = pc_in+1 for BRK (skip padding byte), pc_in otherwise; 16-bit wrap (FFFF+1=0000).
  - Latch sp=sp_in and p=p_in.
  - Go to DUMMY.
- DUMMY: addr=pc_in latched, rw=1.
- PUSH_PCH / PUSH_PCL / PUSH_P:
  - addr={STACK_PAGE, sp}; sp decrements by 1 at the end of each cycle, 8-bit wrap (00 -> FF).
  - data_out = push_pc[15:8], push_pc[7:0], then pushed P.
  - Pushed P = p with bit5=1 and bit4=1 for BRK, bit4=0 otherwise.
  - RST kind: rw=1 in all three cycles (no writes), SP still decrements by 3.
  - Other kinds: rw=0.
- VEC_LO: addr=vector, rw=1; data_in latched at the end of the cycle.
- VEC_HI: addr=vector+1, rw=1.
- Edge ending VEC_HI:
  - pc_out={data_in, vec_lo}, sp_out=sp.
  - Pulse pc_we, sp_we, set_i and done for the following cycle.
  - Pulse nmi_ack if vector==VEC_NMI.
  - Return to IDLE.
- Latency: start accepted at edge N; done/pc_we high during cycle N+6 to N+7; busy high for cycles N+0 to N+6 (6 cycles).
- start during the done cycle is accepted (back-to-back entry).
- start while busy is ignored.
- Request inputs are ignored after the start edge, except under NMI_HIJACK_EN.
- data_out=0 and rw=1 whenever not in a push-write cycle.
- Async reset mid-sequence:
  - Immediate return to IDLE.
  - No pc_we/sp_we/set_i pulse; partial SP changes discarded.

Optional Feature:
- Macro NMI_HIJACK_EN.
- Defined:
  - For IRQ/BRK kinds, req_nmi sampled high at the edge ending PUSH_PCH, PUSH_PCL or PUSH_P switches the vector to VEC_NMI.
  - Pushed B bit stays as latched.
  - nmi_ack pulses with done.
- Not defined: vector fixed at start; a late NMI is taken by a following sequence.

Test Plan:
- IRQ:
  - Stimulus: pc_in=1234, p_in=00, sp_in=FD; vector data 00,80.
  - Bus: rd 1234; wr 01FD=12; wr 01FC=34; wr 01FB=20; rd FFFE; rd FFFF.
  - Response: pc_out=8000, sp_out=FA, set_i, pc_we at start+6.
- BRK (no requests):
  - Stimulus: pc_in=0200, p_in=C3, sp_in=FF.
  - Response: writes 01FF=02, 01FE=01, 01FD=F3; vector FFFE; sp_out=FC.
- RST:
  - Stimulus: req_rst=1, sp_in=00; vector data 00,C0.
  - Response: reads at 0100, 01FF, 01FE, rw=1 throughout; vector FFFC; pc_out=C000, sp_out=FD.
- Priority:
  - Stimulus: req_nmi=req_irq=1 at start.
  - Response: vector FFFA, nmi_ack=1.
  - Stimulus: req_rst also 1.
  - Response: vector FFFC, nmi_ack=0.
- Async reset:
  - Stimulus: rst_n pulsed low during PUSH_PCL.
  - Response: busy=0 immediately; no pc_we/sp_we pulse; next start runs the full 6 cycles.
- Hijack:
  - Stimulus: IRQ start, req_nmi rises during PUSH_PCL.
  - Response with NMI_HIJACK_EN: vector FFFA, nmi_ack=1, pushed P bit4=0.
  - Response without: vector FFFE, nmi_ack=0.
